// File: rtl/counter_timer_pkg.sv
// Shared definitions for the counter_timer_n block: mode encodings and
// the per-channel layout of the control register.
package counter_timer_pkg;

    typedef enum logic [1:0] {
        MODE_ONESHOT  = 2'd0,
        MODE_PERIODIC = 2'd1,
        MODE_SQUARE   = 2'd2,
        MODE_FREERUN  = 2'd3
    } mode_e;

    localparam int CTRL_MODE_LO = 0;
    localparam int CTRL_EN      = 2;
    localparam int CTRL_IRQEN   = 3;
    localparam int CTRL_BITS    = 4;

endpackage

// File: rtl/counter_timer_n_channel.sv
// One timer channel: reload/count/armed/OUT state and the four-mode
// down-counter. o_tc is a combinational one-cycle terminal-count flag.
module timer_channel
    import counter_timer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_tick,
    input  logic             i_en,
    input  mode_e            i_mode,
    input  logic             i_wr,
    input  logic [WIDTH-1:0] i_wr_val,
    input  logic             i_mode_ld,
    input  mode_e            i_ld_mode,
    output logic [WIDTH-1:0] o_cnt,
    output logic             o_out,
    output logic             o_tc
);

    logic [WIDTH-1:0] r_reload;
    logic [WIDTH-1:0] r_cnt;
    logic             r_armed;
    logic             r_out;

    logic [WIDTH-1:0] w_reload_nxt;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic             w_armed_nxt;
    logic             w_out_nxt;
    logic             w_tc;
    logic [WIDTH-1:0] w_half;
    logic [WIDTH-1:0] w_cnt_m1;

    assign w_half   = r_reload >> 1;
    assign w_cnt_m1 = r_cnt - WIDTH'(1);

    always_comb begin
        w_reload_nxt = r_reload;
        w_cnt_nxt    = r_cnt;
        w_armed_nxt  = r_armed;
        w_out_nxt    = r_out;
        w_tc         = 1'b0;
        if (i_wr) begin
            w_reload_nxt = i_wr_val;
            w_cnt_nxt    = (i_mode == MODE_SQUARE) ? (i_wr_val >> 1) : i_wr_val;
            w_out_nxt    = 1'b0;
            w_armed_nxt  = 1'b1;
        end else if (i_mode_ld) begin
            w_cnt_nxt    = (i_ld_mode == MODE_SQUARE) ? w_half : r_reload;
            w_out_nxt    = 1'b0;
            w_armed_nxt  = 1'b1;
        end else begin
            // periodic OUT is a single-clk pulse even when ticks are sparse
            if (i_mode == MODE_PERIODIC) w_out_nxt = 1'b0;
            if (i_tick && i_en) begin
                case (i_mode)
                    MODE_ONESHOT: begin
                        if (r_armed && (r_reload != '0)) begin
                            w_cnt_nxt = w_cnt_m1;
                            if (r_cnt == WIDTH'(1)) begin
                                w_out_nxt   = 1'b1;
                                w_armed_nxt = 1'b0;
                                w_tc        = 1'b1;
                            end
                        end
                    end
                    MODE_PERIODIC: begin
                        if (r_reload != '0) begin
                            if (r_cnt == WIDTH'(1)) begin
                                w_cnt_nxt = r_reload;
                                w_out_nxt = 1'b1;
                                w_tc      = 1'b1;
                            end else begin
                                w_cnt_nxt = w_cnt_m1;
                            end
                        end
                    end
                    MODE_SQUARE: begin
                        if (w_half != '0) begin
                            if (r_cnt == WIDTH'(1)) begin
                                w_out_nxt = ~r_out;
                                w_cnt_nxt = w_half;
                                w_tc      = r_out;
                            end else begin
                                w_cnt_nxt = w_cnt_m1;
                            end
                        end
                    end
                    MODE_FREERUN: begin
                        w_cnt_nxt = w_cnt_m1;
                        w_out_nxt = w_cnt_m1[WIDTH-1];
                        w_tc      = (r_cnt == '0);
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_reload <= '0;
            r_cnt    <= '0;
            r_armed  <= 1'b0;
            r_out    <= 1'b0;
        end else begin
            r_reload <= w_reload_nxt;
            r_cnt    <= w_cnt_nxt;
            r_armed  <= w_armed_nxt;
            r_out    <= w_out_nxt;
        end
    end

    assign o_cnt = r_cnt;
    assign o_out = r_out;
    assign o_tc  = w_tc;

endmodule

// File: rtl/counter_timer_n.sv
// NUM_CH-channel down-counter timer: write decode, control register,
// count read-back mux and registered, enable-gated terminal-count irqs.
module counter_timer_n
    import counter_timer_pkg::*;
#(
    parameter int NUM_CH = 3,
    parameter int WIDTH  = 32,
    parameter int SEL_W  = $clog2(NUM_CH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] cnt_tick,
    input  logic              counter_we,
    input  logic [SEL_W-1:0]  counter_ch,
    input  logic [WIDTH-1:0]  counter_val,
    input  logic [SEL_W-1:0]  rd_ch,
    output logic [WIDTH-1:0]  counter_out,
    output logic [NUM_CH-1:0] counter_OUT,
    output logic [NUM_CH-1:0] counter_irq
);

    localparam int CW = NUM_CH * CTRL_BITS;

    logic [CW-1:0]     r_ctrl;
    logic [NUM_CH-1:0] r_irq;
    logic              w_ctrl_we;
    logic [NUM_CH-1:0] w_tc;
    logic [WIDTH-1:0]  w_cnt [NUM_CH];

    assign w_ctrl_we = counter_we && (counter_ch == SEL_W'(NUM_CH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctrl <= '0;
        end else if (w_ctrl_we) begin
            r_ctrl <= counter_val[CW-1:0];
        end
    end

    if (CW < WIDTH) begin : g_unused
        logic w_unused_val;
        assign w_unused_val = ^counter_val[WIDTH-1:CW];
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        mode_e w_mode;
        mode_e w_new_mode;
        logic  w_ch_we;
        logic  w_mode_ld;

        assign w_mode     = mode_e'(r_ctrl[i*CTRL_BITS+CTRL_MODE_LO +: 2]);
        assign w_new_mode = mode_e'(counter_val[i*CTRL_BITS+CTRL_MODE_LO +: 2]);
        assign w_ch_we    = counter_we && (counter_ch == SEL_W'(i));
        // only a change of mode restarts the channel; en/irq_en edits do not
        assign w_mode_ld  = w_ctrl_we && (w_new_mode != w_mode);

        timer_channel #(.WIDTH(WIDTH)) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_tick    (cnt_tick[i]),
            .i_en      (r_ctrl[i*CTRL_BITS+CTRL_EN]),
            .i_mode    (w_mode),
            .i_wr      (w_ch_we),
            .i_wr_val  (counter_val),
            .i_mode_ld (w_mode_ld),
            .i_ld_mode (w_new_mode),
            .o_cnt     (w_cnt[i]),
            .o_out     (counter_OUT[i]),
            .o_tc      (w_tc[i])
        );

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_irq[i] <= 1'b0;
            end else begin
                r_irq[i] <= w_tc[i] & r_ctrl[i*CTRL_BITS+CTRL_IRQEN];
            end
        end
    end

    always_comb begin
        counter_out = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_ch == SEL_W'(i)) counter_out = w_cnt[i];
        end
    end

    assign counter_irq = r_irq;

endmodule

// File: tb/tb_counter_timer_n.sv
// Scoreboard bench for counter_timer_n (8 channels, 32 bits): stimulus
// queues expected outputs per cycle, a monitor pops and compares them.
module tb_counter_timer_n;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  cnt_tick = '0;
    logic        counter_we = 1'b0;
    logic [3:0]  counter_ch = '0;
    logic [31:0] counter_val = '0;
    logic [3:0]  rd_ch = '0;
    logic [31:0] counter_out;
    logic [7:0]  counter_OUT;
    logic [7:0]  counter_irq;

    counter_timer_n #(.NUM_CH(8), .WIDTH(32), .SEL_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cnt_tick    (cnt_tick),
        .counter_we  (counter_we),
        .counter_ch  (counter_ch),
        .counter_val (counter_val),
        .rd_ch       (rd_ch),
        .counter_out (counter_out),
        .counter_OUT (counter_OUT),
        .counter_irq (counter_irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          tag;
        int          kind;   // 0 counter_out, 1 counter_OUT, 2 counter_irq
        logic [31:0] exp;
        string       nm;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;
    event chk_now;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        exp_t        e;
        logic [31:0] got;
        forever begin
            @(posedge clk or chk_now);
            #1;
            while (q.size() > 0 && q[0].tag <= cyc) begin
                e = q.pop_front();
                case (e.kind)
                    0:       got = counter_out;
                    1:       got = {24'h0, counter_OUT};
                    default: got = {24'h0, counter_irq};
                endcase
                n_chk++;
                if (got !== e.exp) begin
                    n_err++;
                    $display("FAIL %s: got %h expected %h (cycle %0d)", e.nm, got, e.exp, cyc);
                end
            end
        end
    end

    task automatic push(input int tag, input int k, input logic [31:0] v, input string nm);
        exp_t e;
        e.tag = tag; e.kind = k; e.exp = v; e.nm = nm;
        q.push_back(e);
    endtask

    // expectation for the state after the coming clock edge
    task automatic ex(input int k, input logic [31:0] v, input string nm);
        push(cyc + 1, k, v, nm);
    endtask

    task automatic step(input logic [7:0] tk, input logic we, input logic [3:0] ch,
                        input logic [31:0] val);
        cnt_tick = tk; counter_we = we; counter_ch = ch; counter_val = val;
        @(negedge clk);
        cnt_tick = '0; counter_we = 1'b0;
    endtask

    task automatic idle();
        step(8'h00, 1'b0, 4'd0, 32'h0);
    endtask

    initial begin
        int c;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        ex(1, 0, "rst_out"); ex(2, 0, "rst_irq"); ex(0, 0, "rst_cnt");
        idle();

        // one-shot on ch0, reload 5, seven ticks
        step(8'h00, 1'b1, 4'd8, 32'h0000_000C);
        rd_ch = 4'd0;
        ex(0, 5, "os_load");
        step(8'h00, 1'b1, 4'd0, 32'd5);
        for (int k = 1; k <= 7; k++) begin
            ex(0, (k <= 5) ? 32'(5 - k) : 32'd0, "os_cnt");
            if (k == 5) begin ex(1, 32'h01, "os_out"); ex(2, 32'h01, "os_irq"); end
            if (k == 6) begin ex(1, 32'h01, "os_out_hold"); ex(2, 32'h00, "os_irq_end"); end
            step(8'h01, 1'b0, 4'd0, 32'h0);
        end

        // periodic on ch1, reload 3, nine ticks
        step(8'h00, 1'b1, 4'd8, 32'h0000_00DC);
        rd_ch = 4'd1;
        ex(0, 3, "pe_load");
        step(8'h00, 1'b1, 4'd1, 32'd3);
        for (int k = 1; k <= 9; k++) begin
            c = (k % 3 == 0) ? 3 : 3 - (k % 3);
            ex(0, 32'(c), "pe_cnt");
            if (k % 3 == 0) begin ex(1, 32'h03, "pe_out"); ex(2, 32'h02, "pe_irq"); end
            step(8'h02, 1'b0, 4'd0, 32'h0);
            if (k % 3 == 0) begin
                ex(1, 32'h01, "pe_out_end"); ex(2, 32'h00, "pe_irq_end");
                idle();
            end
        end

        // square wave on ch2, reload 8, sixteen ticks
        step(8'h00, 1'b1, 4'd8, 32'h0000_0EDC);
        rd_ch = 4'd2;
        ex(0, 4, "sq_load");
        step(8'h00, 1'b1, 4'd2, 32'd8);
        for (int k = 1; k <= 16; k++) begin
            c = (k % 4 == 0) ? 4 : 4 - (k % 4);
            ex(0, 32'(c), "sq_cnt");
            ex(1, (((k / 4) % 2) == 1) ? 32'h05 : 32'h01, "sq_out");
            ex(2, (k % 8 == 0) ? 32'h04 : 32'h00, "sq_irq");
            step(8'h04, 1'b0, 4'd0, 32'h0);
        end
        ex(0, 0, "sq1_load");
        step(8'h00, 1'b1, 4'd2, 32'd1);
        for (int k = 0; k < 4; k++) begin
            ex(0, 0, "sq1_cnt"); ex(1, 32'h01, "sq1_out");
            step(8'h04, 1'b0, 4'd0, 32'h0);
        end

        // collisions on ch1
        rd_ch = 4'd1;
        ex(0, 10, "col_wr_wins");
        step(8'h02, 1'b1, 4'd1, 32'd10);
        ex(0, 9, "col_tick");
        step(8'h02, 1'b0, 4'd0, 32'h0);
        ex(0, 10, "col_mode_reload");
        step(8'h02, 1'b1, 4'd8, 32'h0000_0ECC);
        ex(0, 9, "col_armed");
        step(8'h02, 1'b0, 4'd0, 32'h0);
        step(8'h00, 1'b1, 4'd8, 32'h0000_0E8C);
        for (int k = 0; k < 3; k++) begin
            ex(0, 9, "col_en0");
            step(8'h02, 1'b0, 4'd0, 32'h0);
        end

        // free-run wrap on ch3
        step(8'h00, 1'b1, 4'd8, 32'h0000_FE8C);
        rd_ch = 4'd3;
        ex(0, 1, "fr_load");
        step(8'h00, 1'b1, 4'd3, 32'd1);
        ex(0, 0, "fr_t1"); ex(1, 32'h01, "fr_t1_out"); ex(2, 0, "fr_t1_irq");
        step(8'h08, 1'b0, 4'd0, 32'h0);
        ex(0, 32'hFFFF_FFFF, "fr_wrap"); ex(1, 32'h09, "fr_out"); ex(2, 32'h08, "fr_irq");
        step(8'h08, 1'b0, 4'd0, 32'h0);
        ex(1, 32'h09, "fr_out_hold"); ex(2, 0, "fr_irq_end");
        idle();

        // out-of-range write selects are ignored
        step(8'h00, 1'b1, 4'd9, 32'h1234_5678);
        step(8'h00, 1'b1, 4'd15, 32'h0);
        ex(0, 32'hFFFF_FFFF, "ign_ch3");
        idle();
        rd_ch = 4'd1;
        ex(0, 9, "ign_ch1");
        idle();
        rd_ch = 4'd9;
        ex(0, 0, "rd_oob");
        idle();
        rd_ch = 4'd3;
        ex(0, 32'hFFFF_FFFE, "ign_ctrl");
        step(8'h08, 1'b0, 4'd0, 32'h0);

        // asynchronous reset mid-run, checked before any clock edge
        #1;
        rst_n = 1'b0;
        push(cyc, 1, 0, "arst_out"); push(cyc, 2, 0, "arst_irq"); push(cyc, 0, 0, "arst_cnt");
        ->chk_now;
        #2;
        for (int r = 0; r < 10; r++) begin
            rd_ch = 4'(r);
            push(cyc, 0, 0, "arst_rd");
            ->chk_now;
            #2;
        end
        @(negedge clk);
        rst_n = 1'b1;
        rd_ch = 4'd3;
        ex(0, 0, "post_rst_cnt"); ex(1, 0, "post_rst_out");
        step(8'hFF, 1'b0, 4'd0, 32'h0);

        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
            n_chk += q.size();
            n_err += q.size();
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/counter_timer_n.md
Name: counter_timer_n

Overview:
- Parametrised successor of the three-channel 8253-style timer.
- NUM_CH independent down-counters of WIDTH bits, all in one clock domain. Each channel advances on a per-channel count-enable strobe instead of its own clock.
- Four modes per channel: one-shot, periodic, square wave, free-run. Each channel has a registered terminal-count interrupt.
- Sits on the CPU peripheral bus beside the GPIO/seven-seg blocks: written through a reload/control port, read back through a selectable count port.

Parameters:
- NUM_CH, 3, number of channels (1..8).
- WIDTH, 32, counter, reload and bus data width; must satisfy 4*NUM_CH <= WIDTH.
- SEL_W, $clog2(NUM_CH+1), width of the write select.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- cnt_tick  in  NUM_CH  per-channel count-enable, one clk wide per count event.
- counter_we  in  1  write strobe.
- counter_ch  in  SEL_W  write target: 0..NUM_CH-1 = channel reload, NUM_CH = control register.
- counter_val  in  WIDTH  write data.
- rd_ch  in  SEL_W  channel whose count is shown on counter_out.
- counter_out  out  WIDTH  current count of channel rd_ch. Combinational mux; 0 if rd_ch >= NUM_CH.
- counter_OUT  out  NUM_CH  registered per-channel output waveform.
- counter_irq  out  NUM_CH  registered one-cycle terminal-count pulse, gated by irq_en.

Behaviour:
- Reset (rst_n low, asynchronous): every reload, cnt, ctrl, counter_OUT and counter_irq bit = 0, and every armed flag = 0.
- Control register write: counter_we with counter_ch == NUM_CH. Channel i takes counter_val[4i+3:4i]:
  - bits [1:0] mode;
  - bit 2 en;
  - bit 3 irq_en.
- Writes with counter_ch > NUM_CH are ignored.
- Channel write: counter_we with counter_ch == i. Next edge: reload_i <= val, cnt_i <= val, counter_OUT[i] <= 0, armed_i <= 1.
- Any control write that changes a channel's mode field reloads that channel: cnt <= reload, OUT <= 0, armed <= 1.
- A write to a channel in the same cycle as its tick: the write wins and the tick is dropped.
- A tick counts only if en = 1; when en = 0 the channel holds all state.
- Reload 0: in modes 0/1/2 the channel is stalled (ticks ignored, OUT = 0). In mode 3 it runs.
- tc_i is an internal one-cycle flag. counter_irq[i] <= tc_i & irq_en_i, so the pulse appears the cycle after the terminal tick.
- Mode 0 (one-shot), on tick with armed:
  - cnt <= cnt-1.
  - If cnt == 1: OUT <= 1, armed <= 0, tc = 1.
  - Unarmed ticks are ignored. OUT stays high until the next channel write.
- Mode 1 (periodic), on tick:
  - If cnt == 1: cnt <= reload, OUT <= 1 for exactly one clk cycle, tc = 1.
  - Otherwise cnt <= cnt-1 and OUT <= 0.
  - Period = reload ticks.
- Mode 2 (square wave):
  - half = reload >> 1. Reload 1 behaves as stalled.
  - Entering the mode or writing the channel sets cnt <= half.
  - On tick: if cnt == 1, OUT <= ~OUT, cnt <= half, and tc = 1 on the 1->0 edge of OUT only. Otherwise cnt <= cnt-1.
  - Period = 2*half ticks; an odd reload loses its LSB.
- Mode 3 (free-run):
  - On tick: cnt <= cnt-1, wrapping 0 -> 2^WIDTH-1.
  - tc = 1 on the wrap.
  - OUT = cnt MSB, registered.
- Width rule: all arithmetic is modulo 2^WIDTH. No extra guard bit is kept; terminal detection is by compare (cnt == 1 or cnt == 0).
- Reset mid-count aborts immediately to reset values. No partial state survives.

Decomposition:
- Package counter_timer_pkg holds:
  - mode encodings MODE_ONESHOT=0, MODE_PERIODIC=1, MODE_SQUARE=2, MODE_FREERUN=3;
  - control field offsets CTRL_MODE_LO=0, CTRL_EN=2, CTRL_IRQEN=3, CTRL_BITS=4.
- One sub-module, timer_channel (parameter WIDTH), instantiated NUM_CH times in a generate loop. It holds one channel's reload, cnt, armed and OUT state and the four-mode logic.
- The top level holds only write decode, the control register, the counter_out read mux and the irq gating.

Test Plan:
- Reset then idle: pulse rst_n low mid-run -> counter_OUT = 0, counter_irq = 0 and counter_out = 0 for all rd_ch, asynchronously with no clk edge.
- One-shot: ctrl ch0 = en|irq_en|mode0, reload 5, then 7 ticks -> cnt 4,3,2,1,0. OUT rises on the 5th tick; counter_irq[0] pulses one cycle later. Ticks 6-7 leave cnt = 0.
- Periodic: ch1 mode1, reload 3, 9 ticks -> OUT high one clk after ticks 3, 6 and 9; cnt reloads to 3 each time; 3 irq pulses.
- Square: ch2 mode2, reload 8, 16 ticks -> OUT toggles every 4 ticks (low, high, low, high). irq fires only on the falling toggles (ticks 8 and 16). Reload 1 -> OUT stays 0.
- Collisions: tick in the same cycle as a reload write of 10 -> cnt = 10, not 9. Control write changing mode 1->0 mid-count -> cnt = reload, armed. en = 0 -> ticks ignored.
- Free-run wrap and parameters: NUM_CH = 8, WIDTH = 32, mode3, reload 1, 2 ticks -> cnt 0 then 0xFFFFFFFF, irq on the wrap. Writes with counter_ch = 9 have no effect.
